// File: rtl/board_controller_if.sv
// Player/animator handshake and board status bundle for board_controller.
// The controller drives through the master modport; the environment uses slave.
interface board_controller_if;
  logic             drop_request;
  logic [2:0]       column_index;
  logic             token_ready;
  logic [2:0]       final_row;
  logic [2:0]       final_column;
  logic [5:0][15:0] board_red;
  logic [5:0][15:0] board_grn;
  logic             player_move;
  logic             valid_move;
  logic [2:0]       column_out;
  logic             player_turn;
  logic             invalid_move;
  logic             winner_valid;
  logic             winner;
  logic             draw;
  logic             game_over;

  modport master (
    input  drop_request, column_index, token_ready, final_row, final_column,
    output board_red, board_grn, player_move, valid_move, column_out, player_turn,
           invalid_move, winner_valid, winner, draw, game_over
  );

  modport slave (
    output drop_request, column_index, token_ready, final_row, final_column,
    input  board_red, board_grn, player_move, valid_move, column_out, player_turn,
           invalid_move, winner_valid, winner, draw, game_over
  );
endinterface

// File: rtl/board_controller.sv
// Connect-four game controller: validates drops, commits landed tokens to the
// board, then scans the four line directions through the new token, one per cycle.
module board_controller (
  input  logic               clk,
  input  logic               reset,
  board_controller_if.master bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DROP = 2'd1;
  localparam logic [1:0] CHECK     = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;
  localparam logic [5:0] MAX_MOVES = 6'd42;

  logic [1:0]       state;
  logic [1:0]       dir_cnt;
  logic [5:0]       move_cnt;
  logic             win_flag;
  logic [2:0]       last_row;
  logic [2:0]       last_col;
  logic [5:0][15:0] board_red;
  logic [5:0][15:0] board_grn;
  logic             player_move, valid_move, invalid_move;
  logic [2:0]       column_out;
  logic             player_turn, winner_valid, winner, draw, game_over;

  logic             req_ok;
  logic             dir_hit;
  logic [5:0][15:0] own_board;
  logic signed [1:0] dr, dc;
  logic [2:0]       line_len;

  function automatic logic [3:0] col_bit(input logic [2:0] c);
    return 4'd15 - {1'b0, c};
  endfunction

  // Same-colour run length stepping away from (r,c), capped at 3 and clipped to the 6x7 grid.
  function automatic logic [1:0] run_len(input logic [5:0][15:0] b,
                                         input logic [2:0] r, input logic [2:0] c,
                                         input logic signed [1:0] sr,
                                         input logic signed [1:0] sc);
    logic signed [4:0] rr, cc;
    logic go;
    run_len = 2'd0;
    go = 1'b1;
    rr = $signed({2'b00, r});
    cc = $signed({2'b00, c});
    for (int k = 0; k < 3; k++) begin
      rr = rr + 5'(sr);
      cc = cc + 5'(sc);
      if (go && rr >= 5'sd0 && rr <= 5'sd5 && cc >= 5'sd0 && cc <= 5'sd6 &&
          b[rr[2:0]][col_bit(cc[2:0])])
        run_len = run_len + 2'd1;
      else
        go = 1'b0;
    end
  endfunction

  always_comb begin
    req_ok = (bus.column_index <= 3'd6) &&
             !board_red[0][col_bit(bus.column_index)] &&
             !board_grn[0][col_bit(bus.column_index)];
    own_board = player_turn ? board_grn : board_red;
    case (dir_cnt)
      2'd0:    begin dr = 2'sd0; dc = 2'sd1;  end
      2'd1:    begin dr = 2'sd1; dc = 2'sd0;  end
      2'd2:    begin dr = 2'sd1; dc = 2'sd1;  end
      default: begin dr = 2'sd1; dc = -2'sd1; end
    endcase
    line_len = {1'b0, run_len(own_board, last_row, last_col, dr, dc)} +
               {1'b0, run_len(own_board, last_row, last_col, -dr, -dc)};
    dir_hit = (line_len >= 3'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      board_red    <= '0;
      board_grn    <= '0;
      player_turn  <= 1'b0;
      player_move  <= 1'b0;
      valid_move   <= 1'b0;
      invalid_move <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      draw         <= 1'b0;
      game_over    <= 1'b0;
      column_out   <= 3'd0;
      move_cnt     <= 6'd0;
      dir_cnt      <= 2'd0;
      win_flag     <= 1'b0;
    end else begin
      player_move  <= 1'b0;
      valid_move   <= 1'b0;
      invalid_move <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.drop_request) begin
            if (req_ok) begin
              player_move <= 1'b1;
              valid_move  <= 1'b1;
              column_out  <= bus.column_index;
              state       <= WAIT_DROP;
            end else begin
              invalid_move <= 1'b1;
            end
          end
        end
        WAIT_DROP: begin
          if (bus.token_ready) begin
            // Off-grid landing cells are never written, keeping the unused board bits clear.
            if (bus.final_row <= 3'd5 && bus.final_column <= 3'd6) begin
              if (player_turn)
                board_grn[bus.final_row][col_bit(bus.final_column)] <= 1'b1;
              else
                board_red[bus.final_row][col_bit(bus.final_column)] <= 1'b1;
            end
            last_row <= bus.final_row;
            last_col <= bus.final_column;
            if (move_cnt != MAX_MOVES)
              move_cnt <= move_cnt + 6'd1;
            dir_cnt  <= 2'd0;
            win_flag <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (dir_cnt == 2'd3) begin
            dir_cnt <= 2'd0;
            if (win_flag || dir_hit) begin
              winner_valid <= 1'b1;
              winner       <= player_turn;
              game_over    <= 1'b1;
              state        <= GAME_OVER;
            end else if (move_cnt == MAX_MOVES) begin
              draw      <= 1'b1;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              player_turn <= ~player_turn;
              state       <= IDLE;
            end
          end else begin
            dir_cnt  <= dir_cnt + 2'd1;
            win_flag <= win_flag | dir_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.board_red    = board_red;
  assign bus.board_grn    = board_grn;
  assign bus.player_move  = player_move;
  assign bus.valid_move   = valid_move;
  assign bus.column_out   = column_out;
  assign bus.player_turn  = player_turn;
  assign bus.invalid_move = invalid_move;
  assign bus.winner_valid = winner_valid;
  assign bus.winner       = winner;
  assign bus.draw         = draw;
  assign bus.game_over    = game_over;
endmodule

// File: tb/tb_board_controller.sv
// Testbench for board_controller: scripted games, table-driven vectors and random
// play checked against a grid-level model of the game rules.
module tb_board_controller;
  logic clk;
  logic reset;
  board_controller_if bus();

  board_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: 0 empty, 1 red, 2 green; row 0 is the top.
  int m_cell [6][7];
  int m_height [8];
  bit m_turn, m_over, m_wv, m_winner, m_draw;
  int m_moves, m_last_r, m_last_c;

  typedef struct {
    logic [2:0] col;
    bit acc;
    bit inv;
    bit turn;
    bit wv;
    bit over;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] m_board(input int p);
    logic [95:0] v = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (m_cell[r][c] == p) v[r*16 + 15 - c] = 1'b1;
    return v;
  endfunction

  // A win exists if some window of four consecutive cells through (r,c) is all colour p.
  function automatic bit four_through(input int r, input int c, input int p);
    int dr[4];
    int dc[4];
    int rr, cc;
    bit ok;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++)
      for (int s = -3; s <= 0; s++) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          rr = r + (s + i) * dr[d];
          cc = c + (s + i) * dc[d];
          if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
          else if (m_cell[rr][cc] != p) ok = 1'b0;
        end
        if (ok) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) m_cell[r][c] = 0;
    for (int c = 0; c < 8; c++) m_height[c] = 0;
    m_turn = 0; m_over = 0; m_wv = 0; m_winner = 0; m_draw = 0; m_moves = 0;
  endtask

  task automatic model_place(input int col);
    m_last_r = 5 - m_height[col];
    m_last_c = col;
    m_cell[m_last_r][col] = m_turn ? 2 : 1;
    m_height[col]++;
    if (m_moves < 42) m_moves++;
  endtask

  task automatic model_decide();
    if (four_through(m_last_r, m_last_c, m_turn ? 2 : 1)) begin
      m_wv = 1; m_winner = m_turn; m_over = 1;
    end else if (m_moves == 42) begin
      m_draw = 1; m_over = 1;
    end else begin
      m_turn = ~m_turn;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_board_red"}, bus.board_red, m_board(1));
    check({tag, "_board_grn"}, bus.board_grn, m_board(2));
    check({tag, "_player_turn"}, bus.player_turn, m_turn);
    check({tag, "_winner_valid"}, bus.winner_valid, m_wv);
    check({tag, "_winner"}, bus.winner, m_winner);
    check({tag, "_draw"}, bus.draw, m_draw);
    check({tag, "_game_over"}, bus.game_over, m_over);
  endtask

  task automatic do_reset();
    bus.drop_request = 1'b0; bus.column_index = 3'd0;
    bus.token_ready = 1'b0; bus.final_row = 3'd0; bus.final_column = 3'd0;
    reset = 1'b1;
    step();
    step();
    model_reset();
    check_state("reset");
    check("reset_column_out", bus.column_out, 3'd0);
    check("reset_pulses", {bus.player_move, bus.valid_move, bus.invalid_move}, 3'b000);
    reset = 1'b0;
  endtask

  // One request plus, if accepted, the animator landing and the four scan cycles.
  task automatic do_move(input logic [2:0] col, input bit noise, output bit got_acc, output bit got_inv);
    bit exp_acc, exp_inv;
    int n;
    exp_acc = !m_over && (col <= 3'd6) && (m_height[col] < 6);
    exp_inv = !m_over && !exp_acc;
    bus.drop_request = 1'b1;
    bus.column_index = col;
    step();
    bus.drop_request = 1'b0;
    got_acc = bus.player_move;
    got_inv = bus.invalid_move;
    check("player_move", bus.player_move, exp_acc);
    check("valid_move", bus.valid_move, exp_acc);
    check("invalid_move", bus.invalid_move, exp_inv);
    if (!exp_acc) begin
      check_state("reject");
      return;
    end
    check("column_out", bus.column_out, col);
    n = noise ? $urandom_range(0, 3) : 0;
    for (int i = 0; i < n; i++) begin
      bus.drop_request = 1'($urandom & 1);
      bus.column_index = 3'($urandom);
      step();
      check("wait_quiet", {bus.player_move, bus.valid_move, bus.invalid_move}, 3'b000);
    end
    bus.drop_request = 1'b0;
    bus.token_ready = 1'b1;
    bus.final_row = 3'(5 - m_height[col]);
    bus.final_column = col;
    step();
    bus.token_ready = 1'b0;
    model_place(col);
    check("commit_red", bus.board_red, m_board(1));
    check("commit_grn", bus.board_grn, m_board(2));
    check("move_pulse_once", bus.player_move, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      bus.drop_request = noise ? 1'($urandom & 1) : 1'b0;
      bus.column_index = 3'($urandom);
      step();
      check("scan_hold_turn", bus.player_turn, m_turn);
      check("scan_no_over", bus.game_over, 1'b0);
      check("scan_quiet", {bus.player_move, bus.invalid_move}, 2'b00);
    end
    bus.drop_request = 1'b0;
    step();
    model_decide();
    check_state("decide");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    bit a, iv;
    int seq[$];
    int diag_seq[12];
    int edge_seq[5];
    logic [95:0] red_snap, grn_snap;
    int extra;

    checks = 0;
    failures = 0;
    reset = 1'b1;

    vt[0] = '{col: 3'd7, acc: 0, inv: 1, turn: 0, wv: 0, over: 0};
    vt[1] = '{col: 3'd0, acc: 1, inv: 0, turn: 1, wv: 0, over: 0};
    vt[2] = '{col: 3'd1, acc: 1, inv: 0, turn: 0, wv: 0, over: 0};
    vt[3] = '{col: 3'd0, acc: 1, inv: 0, turn: 1, wv: 0, over: 0};
    vt[4] = '{col: 3'd1, acc: 1, inv: 0, turn: 0, wv: 0, over: 0};
    vt[5] = '{col: 3'd0, acc: 1, inv: 0, turn: 1, wv: 0, over: 0};
    vt[6] = '{col: 3'd1, acc: 1, inv: 0, turn: 0, wv: 0, over: 0};
    vt[7] = '{col: 3'd0, acc: 1, inv: 0, turn: 0, wv: 1, over: 1};
    vt[8] = '{col: 3'd3, acc: 0, inv: 0, turn: 0, wv: 1, over: 1};

    // Single drop into column 3.
    do_reset();
    do_move(3'd3, 1'b0, a, iv);
    check("single_accept", a, 1'b1);
    check("single_bit_red_5_12", bus.board_red[5][12], 1'b1);
    check("single_turn", bus.player_turn, 1'b1);

    // Vertical red win with an out-of-range request first, driven from the table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_move(vt[i].col, 1'b0, a, iv);
      check("tbl_accept", a, vt[i].acc);
      check("tbl_invalid", iv, vt[i].inv);
      check("tbl_turn", bus.player_turn, vt[i].turn);
      check("tbl_winner_valid", bus.winner_valid, vt[i].wv);
      check("tbl_game_over", bus.game_over, vt[i].over);
    end
    check("vertical_winner", bus.winner, 1'b0);

    // Full column rejects further requests without touching the board.
    do_reset();
    for (int i = 0; i < 6; i++) do_move(3'd0, 1'b0, a, iv);
    red_snap = bus.board_red;
    grn_snap = bus.board_grn;
    do_move(3'd0, 1'b0, a, iv);
    check("full_col_invalid", iv, 1'b1);
    check("full_col_no_move", a, 1'b0);
    check("full_col_red_kept", bus.board_red, red_snap);
    check("full_col_grn_kept", bus.board_grn, grn_snap);

    // Green anti-diagonal (5,1)(4,2)(3,3)(2,4).
    do_reset();
    diag_seq = '{2, 1, 3, 2, 4, 6, 3, 3, 4, 5, 4, 4};
    for (int i = 0; i < 12; i++) do_move(3'(diag_seq[i]), 1'b0, a, iv);
    check("diag_winner_valid", bus.winner_valid, 1'b1);
    check("diag_winner", bus.winner, 1'b1);
    check("diag_game_over", bus.game_over, 1'b1);

    // Three red in a row ending at column 6 is not a win.
    do_reset();
    edge_seq = '{4, 0, 5, 0, 6};
    for (int i = 0; i < 5; i++) do_move(3'(edge_seq[i]), 1'b0, a, iv);
    check("edge_no_win", bus.winner_valid, 1'b0);
    check("edge_not_over", bus.game_over, 1'b0);
    check("edge_turn", bus.player_turn, 1'b1);

    // Draw: columns 0,1,4,5 hold R/G alternating from the bottom, 2,3,6 hold G/R.
    do_reset();
    seq.delete();
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 3; r++) begin
        int ca, cb;
        ca = (p == 0) ? 0 : (p == 1) ? 1 : 4;
        cb = (p == 0) ? 2 : (p == 1) ? 3 : 6;
        seq.push_back(ca); seq.push_back(cb); seq.push_back(cb); seq.push_back(ca);
      end
    for (int i = 0; i < 6; i++) seq.push_back(5);
    foreach (seq[i]) do_move(3'(seq[i]), 1'b0, a, iv);
    check("draw_flag", bus.draw, 1'b1);
    check("draw_no_winner", bus.winner_valid, 1'b0);
    check("draw_game_over", bus.game_over, 1'b1);
    do_move(3'd2, 1'b0, a, iv);
    check("draw_ignore_req", {a, iv}, 2'b00);

    // Reset coinciding with token_ready abandons the move.
    do_reset();
    bus.drop_request = 1'b1; bus.column_index = 3'd2;
    step();
    bus.drop_request = 1'b0;
    check("rst_mid_accept", bus.player_move, 1'b1);
    bus.token_ready = 1'b1; bus.final_row = 3'd5; bus.final_column = 3'd2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.token_ready = 1'b0;
    model_reset();
    check_state("rst_wait");
    do_move(3'd2, 1'b0, a, iv);
    check("rst_wait_idle_after", a, 1'b1);

    // Reset during the direction scan.
    do_reset();
    bus.drop_request = 1'b1; bus.column_index = 3'd1;
    step();
    bus.drop_request = 1'b0;
    bus.token_ready = 1'b1; bus.final_row = 3'd5; bus.final_column = 3'd1;
    step();
    bus.token_ready = 1'b0;
    check("rst_scan_committed", bus.board_red[5][14], 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) step();
    check_state("rst_scan");

    // Random play.
    for (int g = 0; g < 6; g++) begin
      do_reset();
      extra = 0;
      for (int m = 0; m < 80; m++) begin
        do_move(3'($urandom_range(0, 7)), 1'b1, a, iv);
        if (m_over) extra++;
        if (extra >= 2) break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
